stack_register_bank: RTL and testbench

Parametrised general-purpose register bank for the bus-based CPU datapath. It holds NREGS registers of WIDTH bits and replaces the discrete register/tri-state pairs. Bus writes use one-hot load enables; bus reads use output enables, and the block reports a read collision when more than one is asserted. The top register is a hardware stack pointer with push/pop, full/empty detection and sticky error flags. It supplies the RAM stack address.

---
 rtl/stack_register_bank.sv | 143 ++++++++++++++
 tb/tb_stack_register_bank.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_register_bank.sv
// -----------------------------------------------------------------------------
// stack_register_bank
//
// General-purpose register bank for the bus-based CPU datapath. It holds NREGS
// registers of WIDTH bits. The highest register (index NREGS-1) is a hardware
// stack pointer with push/pop stepping, full/empty detection and sticky error
// flags, and it supplies the RAM address for stack accesses.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   bus_in         shared-bus value, loaded into every register whose rin bit is set
//   rin            one load enable per register
//   rout           one output enable per register; the lowest set index wins
//   bus_out        selected register value (0 when no rout bit is set)
//   bus_drive      any rout bit set; gates the external tri-state
//   sp_push        push request
//   sp_pop         pop request
//   sp_addr        RAM address of the current stack access (SP on a push, SP+1 otherwise)
//   stack_empty    SP == STACK_TOP
//   stack_full     SP == STACK_BASE-1
//   err_overflow   sticky: push attempted while full
//   err_underflow  sticky: pop attempted while empty
//   err_contention sticky: more than one rout bit set
//   err_clear      clears the sticky flags (a simultaneous new error wins)
//   regs_flat      all registers packed, register i at [i*WIDTH +: WIDTH]
// -----------------------------------------------------------------------------
module stack_register_bank #(
    parameter int               WIDTH      = 16,
    parameter int               NREGS      = 8,
    parameter logic [WIDTH-1:0] STACK_TOP  = 16'h00FF,
    parameter logic [WIDTH-1:0] STACK_BASE = 16'h0080
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       bus_in,
    input  logic [NREGS-1:0]       rin,
    input  logic [NREGS-1:0]       rout,
    output logic [WIDTH-1:0]       bus_out,
    output logic                   bus_drive,
    input  logic                   sp_push,
    input  logic                   sp_pop,
    output logic [WIDTH-1:0]       sp_addr,
    output logic                   stack_empty,
    output logic                   stack_full,
    output logic                   err_overflow,
    output logic                   err_underflow,
    output logic                   err_contention,
    input  logic                   err_clear,
    output logic [NREGS*WIDTH-1:0] regs_flat
);

    localparam int               SP_IDX   = NREGS - 1;
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [NREGS-1:0] ONE_N    = {{(NREGS-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] FULL_VAL = STACK_BASE - ONE_W;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             cont_q, cont_d;

    logic [WIDTH-1:0] sp_q;
    logic             push_only, pop_only, sp_wr;
    logic             push_step, pop_step;
    logic             ovf_evt, unf_evt, cont_evt;

    assign sp_q        = regs_q[SP_IDX];
    assign stack_empty = (sp_q == STACK_TOP);
    assign stack_full  = (sp_q == FULL_VAL);

    // Push and pop together is treated as idle.
    assign push_only = sp_push & ~sp_pop;
    assign pop_only  = sp_pop & ~sp_push;

    // A bus write to SP overrides any stack request in the same cycle,
    // including its error reporting.
    assign sp_wr     = rin[SP_IDX];
    assign push_step = push_only & ~stack_full  & ~sp_wr;
    assign pop_step  = pop_only  & ~stack_empty & ~sp_wr;
    assign ovf_evt   = push_only & stack_full   & ~sp_wr;
    assign unf_evt   = pop_only  & stack_empty  & ~sp_wr;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign cont_evt  = |(rout & (rout - ONE_N));

    // A push writes the free slot SP; everything else addresses the current top.
    assign sp_addr   = (push_only && !stack_full) ? sp_q : sp_q + ONE_W;

    assign bus_drive = |rout;

    always_comb begin
        bus_out = '0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (rout[i]) begin
                bus_out = regs_q[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = rin[i] ? bus_in : regs_q[i];
        end
        if (push_step) begin
            regs_d[SP_IDX] = sp_q - ONE_W;
        end else if (pop_step) begin
            regs_d[SP_IDX] = sp_q + ONE_W;
        end
    end

    assign ovf_d  = (ovf_q  & ~err_clear) | ovf_evt;
    assign unf_d  = (unf_q  & ~err_clear) | unf_evt;
    assign cont_d = (cont_q & ~err_clear) | cont_evt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == SP_IDX) ? STACK_TOP : '0;
            end
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            cont_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            cont_q <= cont_d;
        end
    end

    assign err_overflow   = ovf_q;
    assign err_underflow  = unf_q;
    assign err_contention = cont_q;

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign regs_flat[g*WIDTH +: WIDTH] = regs_q[g];
    end

endmodule

// File: tb/tb_stack_register_bank.sv
module tb_stack_register_bank;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [15:0]  bus_in = '0;
    logic [7:0]   rin = '0;
    logic [7:0]   rout = '0;
    logic         sp_push = 1'b0;
    logic         sp_pop = 1'b0;
    logic         err_clear = 1'b0;
    logic [15:0]  bus_out;
    logic         bus_drive;
    logic [15:0]  sp_addr;
    logic         stack_empty, stack_full;
    logic         err_overflow, err_underflow, err_contention;
    logic [127:0] regs_flat;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [15:0] m_r [8];
    logic        m_ov, m_un, m_ct;

    stack_register_bank dut (
        .clk           (clk),
        .rst           (rst),
        .bus_in        (bus_in),
        .rin           (rin),
        .rout          (rout),
        .bus_out       (bus_out),
        .bus_drive     (bus_drive),
        .sp_push       (sp_push),
        .sp_pop        (sp_pop),
        .sp_addr       (sp_addr),
        .stack_empty   (stack_empty),
        .stack_full    (stack_full),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow),
        .err_contention(err_contention),
        .err_clear     (err_clear),
        .regs_flat     (regs_flat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
        m_r[7] = 16'h00FF;
        m_ov = 1'b0; m_un = 1'b0; m_ct = 1'b0;
    endtask

    // Compare every output against what the model says for the current inputs.
    task automatic model_compare();
        logic [15:0]  e_bus, sp, e_addr;
        logic         e_empty, e_full, found;
        logic [127:0] e_flat;
        sp      = m_r[7];
        e_empty = (sp == 16'h00FF);
        e_full  = (sp == 16'h007F);
        e_bus   = 16'h0000;
        found   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rout[i] && !found) begin
                e_bus = m_r[i];
                found = 1'b1;
            end
        end
        e_addr = (sp_push && !sp_pop && !e_full) ? sp : 16'(sp + 16'd1);
        for (int i = 0; i < 8; i++) e_flat[i*16 +: 16] = m_r[i];
        chk("bus_out",     bus_out,     e_bus);
        chk("bus_drive",   bus_drive,   rout != 8'h00);
        chk("sp_addr",     sp_addr,     e_addr);
        chk("stack_empty", stack_empty, e_empty);
        chk("stack_full",  stack_full,  e_full);
        chk("err_flags",   {err_overflow, err_underflow, err_contention}, {m_ov, m_un, m_ct});
        chk("regs_flat",   regs_flat,   e_flat);
    endtask

    // Drive inputs on the falling edge and check the combinational response.
    task automatic apply(input logic [15:0] b, input logic [7:0] ri, input logic [7:0] ro,
                         input logic ps, input logic pp, input logic ec);
        @(negedge clk);
        bus_in = b; rin = ri; rout = ro;
        sp_push = ps; sp_pop = pp; err_clear = ec;
        #1;
        model_compare();
    endtask

    // Clock edge: advance the model by the spec's rules for the applied inputs.
    task automatic tick();
        logic [15:0] sp;
        logic        full, empty, ov_e, un_e, ct_e;
        @(posedge clk);
        sp    = m_r[7];
        full  = (sp == 16'h007F);
        empty = (sp == 16'h00FF);
        ov_e  = 1'b0; un_e = 1'b0;
        ct_e  = ($countones(rout) >= 2);
        for (int i = 0; i < 8; i++) if (rin[i]) m_r[i] = bus_in;
        if (!rin[7]) begin
            if (sp_push && !sp_pop) begin
                if (full) ov_e = 1'b1; else m_r[7] = 16'(sp - 16'd1);
            end else if (sp_pop && !sp_push) begin
                if (empty) un_e = 1'b1; else m_r[7] = 16'(sp + 16'd1);
            end
        end
        if (err_clear) begin
            m_ov = 1'b0; m_un = 1'b0; m_ct = 1'b0;
        end
        m_ov = m_ov | ov_e;
        m_un = m_un | un_e;
        m_ct = m_ct | ct_e;
    endtask

    task automatic cyc(input logic [15:0] b, input logic [7:0] ri, input logic [7:0] ro,
                       input logic ps, input logic pp, input logic ec);
        apply(b, ri, ro, ps, pp, ec);
        tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus_in = '0; rin = '0; rout = '0;
        sp_push = 0; sp_pop = 0; err_clear = 0;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [15:0] b;
        logic [7:0]  ri, ro;
        model_reset();
        #12 rst = 1'b1;

        // Reset state, literal
        apply(16'h0, 8'h00, 8'h00, 0, 0, 0);
        chk("rst_sp",      regs_flat[127:112], 16'h00FF);
        chk("rst_empty",   stack_empty, 1'b1);
        chk("rst_full",    stack_full,  1'b0);
        chk("rst_addr",    sp_addr,     16'h0100);
        chk("rst_drive",   bus_drive,   1'b0);
        chk("rst_bus",     bus_out,     16'h0000);
        tick();

        // Broadcast write, read next cycle
        cyc(16'h1234, 8'h05, 8'h00, 0, 0, 0);
        apply(16'h0, 8'h00, 8'h04, 0, 0, 0);
        chk("wr_bus",   bus_out,         16'h1234);
        chk("wr_drive", bus_drive,       1'b1);
        chk("wr_r0",    regs_flat[15:0], 16'h1234);
        chk("wr_r1",    regs_flat[31:16], 16'h0000);
        chk("wr_r2",    regs_flat[47:32], 16'h1234);
        tick();

        // Read of a register during its write returns the old value
        apply(16'hBEEF, 8'h01, 8'h01, 0, 0, 0);
        chk("rd_old", bus_out, 16'h1234);
        tick();

        // Contention
        cyc(16'hAAAA, 8'h02, 8'h00, 0, 0, 0);
        cyc(16'h5555, 8'h04, 8'h00, 0, 0, 0);
        apply(16'h0, 8'h00, 8'h06, 0, 0, 0);
        chk("cont_bus", bus_out, 16'hAAAA);
        chk("cont_pre", err_contention, 1'b0);
        tick();
        cyc(16'h0, 8'h00, 8'h00, 0, 0, 0);
        chk("cont_sticky", err_contention, 1'b1);
        cyc(16'h0, 8'h00, 8'h00, 0, 0, 1);
        apply(16'h0, 8'h00, 8'h00, 0, 0, 0);
        chk("cont_clr", err_contention, 1'b0);
        tick();

        // Push 128 times down to full
        for (int i = 0; i < 128; i++) begin
            apply(16'h0, 8'h00, 8'h00, 1, 0, 0);
            chk("push_addr", sp_addr, 16'(16'h00FF - i));
            tick();
        end
        apply(16'h0, 8'h00, 8'h00, 0, 0, 0);
        chk("full_flag", stack_full, 1'b1);
        chk("full_sp",   regs_flat[127:112], 16'h007F);
        tick();
        cyc(16'h0, 8'h00, 8'h00, 1, 0, 0);
        apply(16'h0, 8'h00, 8'h00, 0, 0, 0);
        chk("ovf_sp",   regs_flat[127:112], 16'h007F);
        chk("ovf_flag", err_overflow, 1'b1);
        tick();

        // Underflow, then SP bus write beats a push
        do_reset();
        cyc(16'h0, 8'h00, 8'h00, 0, 1, 0);
        apply(16'h0, 8'h00, 8'h00, 0, 0, 0);
        chk("unf_sp",   regs_flat[127:112], 16'h00FF);
        chk("unf_flag", err_underflow, 1'b1);
        tick();
        cyc(16'h0090, 8'h80, 8'h00, 1, 0, 0);
        apply(16'h0, 8'h00, 8'h00, 0, 0, 0);
        chk("prio_sp",  regs_flat[127:112], 16'h0090);
        chk("prio_ovf", err_overflow, 1'b0);
        tick();

        // Push and pop together, then async reset mid-push
        cyc(16'h00F0, 8'h80, 8'h00, 0, 0, 1);
        apply(16'h0, 8'h00, 8'h00, 1, 1, 0);
        chk("pp_addr", sp_addr, 16'h00F1);
        tick();
        apply(16'h0, 8'h00, 8'h00, 1, 0, 0);
        chk("pp_sp", regs_flat[127:112], 16'h00F0);
        #1 rst = 1'b0;
        #1;
        chk("arst_sp",    regs_flat[127:112], 16'h00FF);
        chk("arst_empty", stack_empty, 1'b1);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        sp_push = 0;
        rst = 1'b1;

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            b  = 16'($urandom);
            ri = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
            if (ri[7]) begin
                case ($urandom_range(0, 3))
                    0: b = 16'h0081;
                    1: b = 16'h00FE;
                    2: b = 16'($urandom_range(16'h007F, 16'h00FF));
                    default: ;
                endcase
            end
            case ($urandom_range(0, 3))
                0: ro = 8'h00;
                1: ro = 8'h01 << $urandom_range(0, 7);
                default: ro = 8'($urandom);
            endcase
            cyc(b, ri, ro, 1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
